// File: rtl/piso_serializer.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB first,
// optional even-parity bit, stop bit, each held for DIV clocks.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             sout_q, sout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end_s;

  // Next-state logic; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    done_d    = 1'b0;
    bit_end_s = (cnt_q == CNT_MAX);
    case (state_q)
      IDLE: begin
        if (load && ready_q) begin
          state_d = START;
          shreg_d = x;
          par_d   = even_parity(x);
          cnt_d   = {CW{1'b0}};
          idx_d   = {IW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d   = {CW{1'b0}};
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_MAX) begin
            idx_d   = {IW{1'b0}};
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
        idx_d   = {IW{1'b0}};
      end
    endcase

    // Line value for the bit period that begins at the coming edge
    case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shreg_d[0];
      PARITY:  sout_d = par_d;
      default: sout_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  // State and registered outputs with asynchronous abort to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      idx_q   <= {IW{1'b0}};
      shreg_q <= {WIDTH{1'b0}};
      par_q   <= 1'b0;
      sout_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sout  = sout_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
